// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX-stage operand forwarding and hazard detection.
// Forwarding checks EX/MEM, then MEM/WB, then a one-cycle WB-hold copy.
// Stalls come from load-use hazards and from a per-register busy scoreboard
// that tracks outstanding multi-cycle (MUL/DIV) destinations.
// Optional build macro HAZ_PERF_CNT_EN adds the stall_cycles and
// fwd_events saturating performance counters.
module hazard_forward_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_RD_PORTS = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]  id_rs,
    input  logic [NUM_RD_PORTS-1:0]             id_rs_valid,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]  idex_rs,
    input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0]  idex_rdata,
    input  logic [ADDR_WIDTH-1:0]               idex_rd,
    input  logic                                idex_reg_w,
    input  logic                                idex_mem_r,
    input  logic [ADDR_WIDTH-1:0]               exmem_rd,
    input  logic                                exmem_reg_w,
    input  logic [DATA_WIDTH-1:0]               exmem_alu_out,
    input  logic [ADDR_WIDTH-1:0]               memwb_rd,
    input  logic                                memwb_reg_w,
    input  logic [DATA_WIDTH-1:0]               memwb_wdata,
    input  logic                                mc_issue,
    input  logic [ADDR_WIDTH-1:0]               mc_issue_rd,
    input  logic                                mc_done,
    input  logic [ADDR_WIDTH-1:0]               mc_done_rd,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]  fwd_data,
    output logic [2*NUM_RD_PORTS-1:0]           fwd_sel,
    output logic                                stall,
    output logic                                flush_idex
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]                         stall_cycles,
    output logic [31:0]                         fwd_events
`endif
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  hold_valid_q;
    logic [ADDR_WIDTH-1:0] hold_rd_q;
    logic [DATA_WIDTH-1:0] hold_data_q;

    logic luseMatch, sbMatch, wawMatch, luse, waw;

    // Per-port priority forwarding; x0 and reset both fall back to the regfile value.
    always_comb begin
        fwd_sel  = '0;
        fwd_data = idex_rdata;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (rst_n && idex_rs[p*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
                if (exmem_reg_w && exmem_rd == idex_rs[p*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    fwd_sel[2*p +: 2]                = 2'd1;
                    fwd_data[p*DATA_WIDTH +: DATA_WIDTH] = exmem_alu_out;
                end else if (memwb_reg_w && memwb_rd == idex_rs[p*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    fwd_sel[2*p +: 2]                = 2'd2;
                    fwd_data[p*DATA_WIDTH +: DATA_WIDTH] = memwb_wdata;
                end else if (hold_valid_q && hold_rd_q == idex_rs[p*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    fwd_sel[2*p +: 2]                = 2'd3;
                    fwd_data[p*DATA_WIDTH +: DATA_WIDTH] = hold_data_q;
                end
            end
        end
    end

    // Load-use, scoreboard and in-flight multi-cycle issue hazards combine into one stall.
    always_comb begin
        luseMatch = 1'b0;
        sbMatch   = 1'b0;
        wawMatch  = 1'b0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (id_rs_valid[p]) begin
                if (id_rs[p*ADDR_WIDTH +: ADDR_WIDTH] == idex_rd)     luseMatch = 1'b1;
                if (busy_q[id_rs[p*ADDR_WIDTH +: ADDR_WIDTH]])        sbMatch   = 1'b1;
                if (id_rs[p*ADDR_WIDTH +: ADDR_WIDTH] == mc_issue_rd) wawMatch  = 1'b1;
            end
        end
        luse       = idex_reg_w && idex_mem_r && (idex_rd != '0) && luseMatch;
        waw        = mc_issue && (mc_issue_rd != '0) && idex_reg_w && !busy_q[idex_rd] && wawMatch;
        stall      = rst_n && (luse || sbMatch || waw);
        flush_idex = stall;
    end

    // Scoreboard next state: clear on completion, then set on issue so set wins.
    always_comb begin
        busy_d = busy_q;
        if (mc_done && mc_done_rd != '0)   busy_d[mc_done_rd]  = 1'b0;
        if (mc_issue && mc_issue_rd != '0) busy_d[mc_issue_rd] = 1'b1;
    end

    // State registers: busy scoreboard and the one-cycle WB-hold copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
        end else begin
            busy_q       <= busy_d;
            hold_valid_q <= memwb_reg_w;
            hold_rd_q    <= memwb_rd;
            hold_data_q  <= memwb_wdata;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] fwdCount;
    logic [32:0] stallSum, fwdSum;

    // Count forwarded ports this cycle and form unsaturated next counter values.
    always_comb begin
        fwdCount = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (fwd_sel[2*p +: 2] != 2'd0) fwdCount = fwdCount + 32'd1;
        end
        stallSum = {1'b0, stall_cycles} + {32'd0, stall};
        fwdSum   = {1'b0, fwd_events} + {1'b0, fwdCount};
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else begin
            stall_cycles <= stallSum[32] ? '1 : stallSum[31:0];
            fwd_events   <= fwdSum[32]   ? '1 : fwdSum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Testbench for hazard_forward_ctrl: directed scenarios plus a randomized
// run checked against a behavioural model of the forwarding/hazard rules.
module tb_hazard_forward_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*AW-1:0]  id_rs;
    logic [NP-1:0]     id_rs_valid;
    logic [NP*AW-1:0]  idex_rs;
    logic [NP*DW-1:0]  idex_rdata;
    logic [AW-1:0]     idex_rd;
    logic              idex_reg_w, idex_mem_r;
    logic [AW-1:0]     exmem_rd;
    logic              exmem_reg_w;
    logic [DW-1:0]     exmem_alu_out;
    logic [AW-1:0]     memwb_rd;
    logic              memwb_reg_w;
    logic [DW-1:0]     memwb_wdata;
    logic              mc_issue, mc_done;
    logic [AW-1:0]     mc_issue_rd, mc_done_rd;
    logic [NP*DW-1:0]  fwd_data;
    logic [2*NP-1:0]   fwd_sel;
    logic              stall, flush_idex;

    int checks = 0;
    int failures = 0;

    // Behavioural model state for the randomized run.
    bit          mBusy [32];
    bit          mHoldValid;
    logic [4:0]  mHoldRd;
    logic [31:0] mHoldData;

    hazard_forward_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD_PORTS(NP)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rs_valid(id_rs_valid),
        .idex_rs(idex_rs), .idex_rdata(idex_rdata),
        .idex_rd(idex_rd), .idex_reg_w(idex_reg_w), .idex_mem_r(idex_mem_r),
        .exmem_rd(exmem_rd), .exmem_reg_w(exmem_reg_w), .exmem_alu_out(exmem_alu_out),
        .memwb_rd(memwb_rd), .memwb_reg_w(memwb_reg_w), .memwb_wdata(memwb_wdata),
        .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
        .mc_done(mc_done), .mc_done_rd(mc_done_rd),
        .fwd_data(fwd_data), .fwd_sel(fwd_sel),
        .stall(stall), .flush_idex(flush_idex)
    );

    // Free-running pipeline clock.
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_rs = '0; id_rs_valid = '0; idex_rs = '0; idex_rdata = '0;
        idex_rd = '0; idex_reg_w = 0; idex_mem_r = 0;
        exmem_rd = '0; exmem_reg_w = 0; exmem_alu_out = '0;
        memwb_rd = '0; memwb_reg_w = 0; memwb_wdata = '0;
        mc_issue = 0; mc_issue_rd = '0; mc_done = 0; mc_done_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        exmem_reg_w = 1; exmem_rd = 5'd3; exmem_alu_out = 32'h55;
        idex_rs = {5'd3, 5'd3};
        idex_rdata = {32'hCAFE0001, 32'hBEEF0002};
        idex_reg_w = 1; idex_mem_r = 1; idex_rd = 5'd4;
        id_rs = {5'd4, 5'd4}; id_rs_valid = 2'b11;
        #2;
        checks++;
        if (fwd_sel !== 4'd0) begin
            failures++; $display("[TB] FAIL reset_sel got=%0h want=0", fwd_sel);
        end
        checks++;
        if (fwd_data !== {32'hCAFE0001, 32'hBEEF0002}) begin
            failures++; $display("[TB] FAIL reset_data got=%0h want=cafe0001beef0002", fwd_data);
        end
        checks++;
        if (stall !== 1'b0 || flush_idex !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_stall got=%b/%b want=0/0", stall, flush_idex);
        end
        tick(); tick();
        rst_n = 1'b1;
        clear_inputs();
        tick();
    endtask

    task automatic test_exmem_priority();
        clear_inputs();
        exmem_rd = 5'd5; exmem_reg_w = 1; exmem_alu_out = 32'h11;
        memwb_rd = 5'd5; memwb_reg_w = 1; memwb_wdata = 32'h22;
        idex_rs = {5'd6, 5'd5}; idex_rdata = {32'h99, 32'h77};
        #1;
        checks++;
        if (fwd_sel[1:0] !== 2'd1 || fwd_data[31:0] !== 32'h11) begin
            failures++; $display("[TB] FAIL exmem_prio got sel=%0d data=%0h want sel=1 data=11", fwd_sel[1:0], fwd_data[31:0]);
        end
        checks++;
        if (fwd_sel[3:2] !== 2'd0 || fwd_data[63:32] !== 32'h99) begin
            failures++; $display("[TB] FAIL exmem_prio_p1 got sel=%0d data=%0h want sel=0 data=99", fwd_sel[3:2], fwd_data[63:32]);
        end
        tick();
    endtask

    task automatic test_wb_hold();
        clear_inputs();
        memwb_rd = 5'd7; memwb_reg_w = 1; memwb_wdata = 32'hABCD;
        tick();
        memwb_reg_w = 0; memwb_rd = 5'd0; memwb_wdata = 32'h0;
        idex_rs = {5'd7, 5'd1}; idex_rdata = {32'h1234, 32'h0};
        #1;
        checks++;
        if (fwd_sel[3:2] !== 2'd3 || fwd_data[63:32] !== 32'hABCD) begin
            failures++; $display("[TB] FAIL wb_hold got sel=%0d data=%0h want sel=3 data=abcd", fwd_sel[3:2], fwd_data[63:32]);
        end
        tick();
        #1;
        checks++;
        if (fwd_sel[3:2] !== 2'd0 || fwd_data[63:32] !== 32'h1234) begin
            failures++; $display("[TB] FAIL wb_hold_expire got sel=%0d data=%0h want sel=0 data=1234", fwd_sel[3:2], fwd_data[63:32]);
        end
        tick();
    endtask

    task automatic test_x0_guard();
        clear_inputs();
        exmem_rd = 5'd0; exmem_reg_w = 1; exmem_alu_out = 32'hDEAD;
        idex_rs = '0; idex_rdata = '0;
        #1;
        checks++;
        if (fwd_sel[1:0] !== 2'd0 || fwd_data[31:0] !== 32'h0) begin
            failures++; $display("[TB] FAIL x0_guard got sel=%0d data=%0h want sel=0 data=0", fwd_sel[1:0], fwd_data[31:0]);
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        idex_reg_w = 1; idex_mem_r = 1; idex_rd = 5'd9;
        id_rs = {5'd9, 5'd2}; id_rs_valid = 2'b10;
        #1;
        checks++;
        if (stall !== 1'b1 || flush_idex !== 1'b1) begin
            failures++; $display("[TB] FAIL load_use got=%b/%b want=1/1", stall, flush_idex);
        end
        tick();
        idex_reg_w = 0; idex_mem_r = 0; idex_rd = 5'd0;
        #1;
        checks++;
        if (stall !== 1'b0 || flush_idex !== 1'b0) begin
            failures++; $display("[TB] FAIL load_use_release got=%b/%b want=0/0", stall, flush_idex);
        end
        idex_reg_w = 1; idex_mem_r = 1; idex_rd = 5'd9; id_rs_valid = 2'b01;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("[TB] FAIL load_use_invalid got=%b want=0", stall);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        clear_inputs();
        mc_issue = 1; mc_issue_rd = 5'd12;
        tick();
        mc_issue = 0;
        id_rs = {5'd0, 5'd12}; id_rs_valid = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin mc_done = 1; mc_done_rd = 5'd12; end
            #1;
            checks++;
            if (stall !== 1'b1 || flush_idex !== 1'b1) begin
                failures++; $display("[TB] FAIL sb_hold_c%0d got=%b/%b want=1/1", c, stall, flush_idex);
            end
            tick();
        end
        mc_done = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("[TB] FAIL sb_release got=%b want=0", stall);
        end
        id_rs_valid = 2'b00;
        mc_issue = 1; mc_issue_rd = 5'd12;
        tick();
        mc_done = 1; mc_done_rd = 5'd12;
        tick();
        mc_issue = 0; mc_done = 0; id_rs_valid = 2'b01;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("[TB] FAIL sb_set_wins got=%b want=1", stall);
        end
    endtask

    task automatic test_reset_mid_stall();
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || flush_idex !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_mid_stall got=%b/%b want=0/0", stall, flush_idex);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("[TB] FAIL post_reset_read got=%b want=0", stall);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [4:0]  rs [NP];
        logic [4:0]  irs [NP];
        logic [31:0] rdat [NP];
        logic [1:0]  expSel;
        logic [31:0] expData;
        bit          expStall, luseHit, sbHit, wawHit;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        rst_n = 1'b1;
        foreach (mBusy[r]) mBusy[r] = 0;
        mHoldValid = 0; mHoldRd = '0; mHoldData = '0;
        tick();
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int p = 0; p < NP; p++) begin
                rs[p] = 5'($urandom_range(7, 0));
                irs[p] = 5'($urandom_range(7, 0));
                rdat[p] = $urandom;
                idex_rs[p*AW +: AW] = rs[p];
                id_rs[p*AW +: AW] = irs[p];
                idex_rdata[p*DW +: DW] = rdat[p];
            end
            id_rs_valid = 2'($urandom);
            idex_rd = 5'($urandom_range(7, 0));
            idex_reg_w = 1'($urandom); idex_mem_r = 1'($urandom);
            exmem_rd = 5'($urandom_range(7, 0)); exmem_reg_w = 1'($urandom); exmem_alu_out = $urandom;
            memwb_rd = 5'($urandom_range(7, 0)); memwb_reg_w = 1'($urandom); memwb_wdata = $urandom;
            mc_issue = ($urandom_range(3, 0) == 0); mc_issue_rd = 5'($urandom_range(7, 0));
            mc_done = ($urandom_range(2, 0) == 0); mc_done_rd = 5'($urandom_range(7, 0));
            #1;
            for (int p = 0; p < NP; p++) begin
                expSel = 2'd0; expData = rdat[p];
                if (rs[p] != 0) begin
                    if (exmem_reg_w && exmem_rd == rs[p]) begin expSel = 1; expData = exmem_alu_out; end
                    else if (memwb_reg_w && memwb_rd == rs[p]) begin expSel = 2; expData = memwb_wdata; end
                    else if (mHoldValid && mHoldRd == rs[p]) begin expSel = 3; expData = mHoldData; end
                end
                checks++;
                if (fwd_sel[2*p +: 2] !== expSel || fwd_data[p*DW +: DW] !== expData) begin
                    failures++;
                    $display("[TB] FAIL rand_fwd c%0d p%0d got sel=%0d data=%0h want sel=%0d data=%0h",
                             cyc, p, fwd_sel[2*p +: 2], fwd_data[p*DW +: DW], expSel, expData);
                end
            end
            luseHit = 0; sbHit = 0; wawHit = 0;
            for (int p = 0; p < NP; p++) begin
                if (id_rs_valid[p]) begin
                    if (idex_reg_w && idex_mem_r && idex_rd != 0 && irs[p] == idex_rd) luseHit = 1;
                    if (mBusy[irs[p]]) sbHit = 1;
                    if (mc_issue && mc_issue_rd != 0 && idex_reg_w && !mBusy[idex_rd] && irs[p] == mc_issue_rd) wawHit = 1;
                end
            end
            expStall = luseHit | sbHit | wawHit;
            checks++;
            if (stall !== expStall || flush_idex !== expStall) begin
                failures++;
                $display("[TB] FAIL rand_stall c%0d got=%b/%b want=%b", cyc, stall, flush_idex, expStall);
            end
            if (mc_done && mc_done_rd != 0) mBusy[mc_done_rd] = 0;
            if (mc_issue && mc_issue_rd != 0) mBusy[mc_issue_rd] = 1;
            mHoldValid = memwb_reg_w; mHoldRd = memwb_rd; mHoldData = memwb_wdata;
            tick();
        end
    endtask

    // Run all scenarios in sequence, then report.
    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_exmem_priority();
        test_wb_hold();
        test_x0_guard();
        test_load_use();
        test_scoreboard();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Parametrised next-generation forwarding and hazard unit for the 5-stage RISC-V pipeline.
- Resolves EX-stage operand forwarding for N read ports from three sources: EX/MEM, MEM/WB, and a registered WB-hold copy that covers write-then-read regfile timing.
- Generates load-use stalls and tracks multi-cycle-unit (MUL/DIV) destinations in a per-register busy scoreboard.
- Sits between the ID/EX pipeline register and the ALU operand muxes; drives the pipeline stall and flush controls.

Parameters:
DATA_WIDTH, 32, operand/result width
ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)
NUM_RD_PORTS, 2, number of source operands forwarded/checked

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_rs  in  NUM_RD_PORTS*ADDR_WIDTH  source registers of instruction in ID
id_rs_valid  in  NUM_RD_PORTS  per-port "operand actually read" in ID
idex_rs  in  NUM_RD_PORTS*ADDR_WIDTH  source registers in EX
idex_rdata  in  NUM_RD_PORTS*DATA_WIDTH  regfile read data carried in ID/EX
idex_rd  in  ADDR_WIDTH  EX destination
idex_reg_w  in  1  EX writes register
idex_mem_r  in  1  EX is a load
exmem_rd  in  ADDR_WIDTH  MEM destination
exmem_reg_w  in  1  MEM writes register
exmem_alu_out  in  DATA_WIDTH  MEM-stage ALU result
memwb_rd  in  ADDR_WIDTH  WB destination
memwb_reg_w  in  1  WB writes register
memwb_wdata  in  DATA_WIDTH  WB write data (load/ALU mux output)
mc_issue  in  1  multi-cycle op leaves EX this cycle
mc_issue_rd  in  ADDR_WIDTH  its destination
mc_done  in  1  multi-cycle result written this cycle
mc_done_rd  in  ADDR_WIDTH  its destination
fwd_data  out  NUM_RD_PORTS*DATA_WIDTH  forwarded EX operands
fwd_sel  out  2*NUM_RD_PORTS  per port: 0 regfile, 1 EX/MEM, 2 MEM/WB, 3 WB-hold
stall  out  1  freeze PC and IF/ID
flush_idex  out  1  insert bubble into ID/EX

Behaviour:
- Reset: async on rst_n low. Clears the scoreboard (all zero), clears hold_valid, and zeroes hold_rd/hold_data.
- Outputs while rst_n is low: stall=0, flush_idex=0, fwd_sel=0, fwd_data=idex_rdata.
- Forwarding is combinational, 0-cycle. Per port p, first match wins:
  - EX/MEM: exmem_reg_w && exmem_rd!=0 && exmem_rd==idex_rs[p] -> sel 1.
  - MEM/WB: same test on memwb_* -> sel 2.
  - WB-hold: hold_valid && hold_rd!=0 && hold_rd==idex_rs[p] -> sel 3.
  - Otherwise sel 0, data = idex_rdata[p].
- An rs of x0 always yields sel 0.
- WB-hold register: on each clk, hold_valid<=memwb_reg_w, hold_rd<=memwb_rd, hold_data<=memwb_wdata. This gives exactly one cycle of extra visibility.
- Load-use: luse = idex_reg_w && idex_mem_r && idex_rd!=0 && any p with id_rs_valid[p] && id_rs[p]==idex_rd.
- Scoreboard:
  - busy[r] set on mc_issue for rd!=0; cleared on mc_done for rd.
  - Same cycle, same rd, both issue and done: set wins (busy stays 1).
  - Issue or done on x0 is ignored.
  - A clear takes effect the next cycle, so the stall drops one cycle after mc_done.
- sb_haz = any p with id_rs_valid[p] && busy[id_rs[p]] (registered busy).
- Write-after-write: sb_haz also asserts if idex_reg_w && busy[idex_rd] is false but the ID instruction's rs matches mc_issue_rd while mc_issue is high.
- stall = luse | sb_haz; flush_idex = stall. Both are combinational from inputs and registered state.
- A stall lasts 1 cycle for load-use. For the scoreboard it persists until the busy bit clears.
- Reset mid-stall: the scoreboard is cleared, so the stall deasserts immediately.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds outputs stall_cycles (32) and fwd_events (32).
  - stall_cycles increments each cycle stall=1.
  - fwd_events increments by the number of ports with sel!=0 in that cycle.
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- EX/MEM priority: exmem_rd=5, memwb_rd=5, idex_rs[0]=5, both reg_w=1, exmem_alu_out=0x11, memwb_wdata=0x22 -> fwd_sel[0]=1, fwd_data[0]=0x11.
- WB-hold: memwb_rd=7, wdata=0xABCD written in cycle N; in cycle N+1 idex_rs[1]=7 with no other match -> sel 3, data 0xABCD. In N+2 -> sel 0.
- x0 guard: exmem_rd=0, exmem_reg_w=1, idex_rs[0]=0, idex_rdata[0]=0 -> sel 0, data 0.
- Load-use: idex_mem_r=1, idex_rd=9, id_rs[1]=9, valid -> stall=1 and flush_idex=1 for exactly 1 cycle. Same case with id_rs_valid[1]=0 -> no stall.
- Scoreboard: mc_issue rd=12. ID reads x12 for the following 4 cycles -> stall held. mc_done rd=12 in cycle 4 -> stall=0 in cycle 5. Simultaneous issue+done on 12 -> busy stays 1.
- Reset mid-stall: busy[12]=1, stall=1, pulse rst_n=0 -> stall=0 immediately; after release, x12 read -> no stall.
